// File: rtl/barrett_red_pipe_if.sv
// Bus bundle for barrett_red_pipe: modulus-table write port plus the valid/ready operand and
// result streams. The master side drives operands and config; the slave side is the reducer.
interface barrett_red_pipe_if #(
    parameter int COE_WIDTH = 39,
    parameter int Q_NUM     = 4,
    parameter int TAG_WIDTH = 8
);

    localparam int QS_W = (Q_NUM > 1) ? $clog2(Q_NUM) : 1;
    localparam int K_W  = $clog2(COE_WIDTH + 1);

    logic                   i_cfg_we;
    logic [QS_W-1:0]        i_cfg_idx;
    logic [COE_WIDTH-1:0]   i_cfg_q;
    logic [K_W-1:0]         i_cfg_k;
    logic [COE_WIDTH:0]     i_cfg_mu;

    logic                   i_vld;
    logic                   o_rdy;
    logic [2*COE_WIDTH-1:0] i_a;
    logic [QS_W-1:0]        i_q_sel;
    logic [TAG_WIDTH-1:0]   i_tag;

    logic                   o_vld;
    logic                   i_rdy;
    logic [COE_WIDTH-1:0]   o_red;
    logic [TAG_WIDTH-1:0]   o_tag;

    modport master (
        output i_cfg_we, i_cfg_idx, i_cfg_q, i_cfg_k, i_cfg_mu,
        output i_vld, i_a, i_q_sel, i_tag, i_rdy,
        input  o_rdy, o_vld, o_red, o_tag
    );

    modport slave (
        input  i_cfg_we, i_cfg_idx, i_cfg_q, i_cfg_k, i_cfg_mu,
        input  i_vld, i_a, i_q_sel, i_tag, i_rdy,
        output o_rdy, o_vld, o_red, o_tag
    );

endinterface

// File: rtl/barrett_red_pipe.sv
// Runtime-configurable Barrett reducer: o_red = i_a mod q[i_q_sel] through a fixed four-stage
// valid/ready pipeline, with a per-slot modulus table and a tag carried alongside each operand.
module barrett_red_pipe #(
    parameter int COE_WIDTH = 39,
    parameter int Q_NUM     = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    barrett_red_pipe_if.slave bus
);

    localparam int QS_W = (Q_NUM > 1) ? $clog2(Q_NUM) : 1;
    localparam int K_W  = $clog2(COE_WIDTH + 1);
    localparam int MW   = COE_WIDTH + 1;
    localparam int PW   = 2 * MW;
    localparam int RW   = COE_WIDTH + 2;

    logic [COE_WIDTH-1:0] tbl_q_q  [Q_NUM];
    logic [COE_WIDTH-1:0] tbl_q_d  [Q_NUM];
    logic [K_W-1:0]       tbl_k_q  [Q_NUM];
    logic [K_W-1:0]       tbl_k_d  [Q_NUM];
    logic [MW-1:0]        tbl_mu_q [Q_NUM];
    logic [MW-1:0]        tbl_mu_d [Q_NUM];

    logic                 s1_vld_q, s1_vld_d;
    logic [RW-1:0]        s1_a_q, s1_a_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic [COE_WIDTH-1:0] s1_q_q, s1_q_d;
    logic [K_W-1:0]       s1_k_q, s1_k_d;
    logic [MW-1:0]        s1_mu_q, s1_mu_d;
    logic [MW-1:0]        s1_t1_q, s1_t1_d;

    logic                 s2_vld_q, s2_vld_d;
    logic [RW-1:0]        s2_a_q, s2_a_d;
    logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
    logic [COE_WIDTH-1:0] s2_q_q, s2_q_d;
    logic [K_W-1:0]       s2_k_q, s2_k_d;
    logic [PW-1:0]        s2_p_q, s2_p_d;

    logic                 s3_vld_q, s3_vld_d;
    logic [RW-1:0]        s3_r_q, s3_r_d;
    logic [TAG_WIDTH-1:0] s3_tag_q, s3_tag_d;
    logic [COE_WIDTH-1:0] s3_q_q, s3_q_d;
    logic                 s3_zero_q, s3_zero_d;

    logic                 out_vld_q, out_vld_d;
    logic [COE_WIDTH-1:0] out_red_q, out_red_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

    logic                 stall;
    logic [COE_WIDTH-1:0] rd_q;
    logic [K_W-1:0]       rd_k;
    logic [MW-1:0]        rd_mu;
    logic [MW-1:0]        qh;
    logic [RW-1:0]        two_q;
    logic [RW-1:0]        one_q;

    always_comb begin
        stall = out_vld_q & ~bus.i_rdy;
    end

    // Table writes land at the sampling edge, so an operand accepted on that edge sees old values.
    always_comb begin
        for (int i = 0; i < Q_NUM; i++) begin
            tbl_q_d[i]  = tbl_q_q[i];
            tbl_k_d[i]  = tbl_k_q[i];
            tbl_mu_d[i] = tbl_mu_q[i];
            if (bus.i_cfg_we && (bus.i_cfg_idx == QS_W'(i))) begin
                tbl_q_d[i]  = bus.i_cfg_q;
                tbl_k_d[i]  = bus.i_cfg_k;
                tbl_mu_d[i] = bus.i_cfg_mu;
            end
        end
    end

    // Select beyond the populated slots reads as an unconfigured (k == 0) slot.
    always_comb begin
        rd_q  = '0;
        rd_k  = '0;
        rd_mu = '0;
        for (int i = 0; i < Q_NUM; i++) begin
            if (bus.i_q_sel == QS_W'(i)) begin
                rd_q  = tbl_q_q[i];
                rd_k  = tbl_k_q[i];
                rd_mu = tbl_mu_q[i];
            end
        end
    end

    always_comb begin
        qh    = MW'(s2_p_q >> (s2_k_q + K_W'(1)));
        two_q = RW'({s3_q_q, 1'b0});
        one_q = RW'(s3_q_q);
    end

    // Every stage holds on stall; no bubble collapsing.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_a_d    = s1_a_q;
        s1_tag_d  = s1_tag_q;
        s1_q_d    = s1_q_q;
        s1_k_d    = s1_k_q;
        s1_mu_d   = s1_mu_q;
        s1_t1_d   = s1_t1_q;
        s2_vld_d  = s2_vld_q;
        s2_a_d    = s2_a_q;
        s2_tag_d  = s2_tag_q;
        s2_q_d    = s2_q_q;
        s2_k_d    = s2_k_q;
        s2_p_d    = s2_p_q;
        s3_vld_d  = s3_vld_q;
        s3_r_d    = s3_r_q;
        s3_tag_d  = s3_tag_q;
        s3_q_d    = s3_q_q;
        s3_zero_d = s3_zero_q;
        out_vld_d = out_vld_q;
        out_red_d = out_red_q;
        out_tag_d = out_tag_q;
        if (!stall) begin
            s1_vld_d  = bus.i_vld;
            s1_a_d    = RW'(bus.i_a);
            s1_tag_d  = bus.i_tag;
            s1_q_d    = rd_q;
            s1_k_d    = rd_k;
            s1_mu_d   = rd_mu;
            s1_t1_d   = MW'(bus.i_a >> (rd_k - K_W'(1)));

            s2_vld_d  = s1_vld_q;
            s2_a_d    = s1_a_q;
            s2_tag_d  = s1_tag_q;
            s2_q_d    = s1_q_q;
            s2_k_d    = s1_k_q;
            s2_p_d    = PW'(s1_t1_q) * PW'(s1_mu_q);

            // Only the low RW bits of a - qh*q matter: the true remainder is below 3q.
            s3_vld_d  = s2_vld_q;
            s3_r_d    = s2_a_q - (RW'(qh) * RW'(s2_q_q));
            s3_tag_d  = s2_tag_q;
            s3_q_d    = s2_q_q;
            s3_zero_d = (s2_k_q == '0);

            out_vld_d = s3_vld_q;
            out_tag_d = s3_tag_q;
            if (s3_zero_q) begin
                out_red_d = '0;
            end else if (s3_r_q >= two_q) begin
                out_red_d = COE_WIDTH'(s3_r_q - two_q);
            end else if (s3_r_q >= one_q) begin
                out_red_d = COE_WIDTH'(s3_r_q - one_q);
            end else begin
                out_red_d = COE_WIDTH'(s3_r_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Q_NUM; i++) begin
                tbl_q_q[i]  <= '0;
                tbl_k_q[i]  <= '0;
                tbl_mu_q[i] <= '0;
            end
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_tag_q  <= '0;
            s1_q_q    <= '0;
            s1_k_q    <= '0;
            s1_mu_q   <= '0;
            s1_t1_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_a_q    <= '0;
            s2_tag_q  <= '0;
            s2_q_q    <= '0;
            s2_k_q    <= '0;
            s2_p_q    <= '0;
            s3_vld_q  <= 1'b0;
            s3_r_q    <= '0;
            s3_tag_q  <= '0;
            s3_q_q    <= '0;
            s3_zero_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_red_q <= '0;
            out_tag_q <= '0;
        end else begin
            for (int i = 0; i < Q_NUM; i++) begin
                tbl_q_q[i]  <= tbl_q_d[i];
                tbl_k_q[i]  <= tbl_k_d[i];
                tbl_mu_q[i] <= tbl_mu_d[i];
            end
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_tag_q  <= s1_tag_d;
            s1_q_q    <= s1_q_d;
            s1_k_q    <= s1_k_d;
            s1_mu_q   <= s1_mu_d;
            s1_t1_q   <= s1_t1_d;
            s2_vld_q  <= s2_vld_d;
            s2_a_q    <= s2_a_d;
            s2_tag_q  <= s2_tag_d;
            s2_q_q    <= s2_q_d;
            s2_k_q    <= s2_k_d;
            s2_p_q    <= s2_p_d;
            s3_vld_q  <= s3_vld_d;
            s3_r_q    <= s3_r_d;
            s3_tag_q  <= s3_tag_d;
            s3_q_q    <= s3_q_d;
            s3_zero_q <= s3_zero_d;
            out_vld_q <= out_vld_d;
            out_red_q <= out_red_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign bus.o_rdy = ~stall;
    assign bus.o_vld = out_vld_q;
    assign bus.o_red = out_red_q;
    assign bus.o_tag = out_tag_q;

endmodule
